// File: rtl/branch_resolve_ctrl.sv
// ============================================================================
// Module   : branch_resolve_ctrl
// Brief    : EX-stage branch sequencer. Maps funct3 to the compare-unit op,
//            resolves the outcome, checks the prediction, issues redirect and
//            flush on mispredict. The 2-bit BHT exists only when
//            BRANCH_RESOLVE_CTRL_BHT_EN is defined; otherwise static not-taken.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_ctrl #(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_funct3,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_target,
    input  logic        br_pred_taken,
    output logic [2:0]  cmp_op,
    input  logic [31:0] cmp_result,
    input  logic [31:0] lookup_pc,
    output logic        lookup_taken,
    output logic        resolved_valid,
    output logic        resolved_taken,
    output logic        illegal_branch,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_if,
    output logic        flush_id
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_compare = 2'd1;
    localparam logic [1:0] c_st_resolve = 2'd2;
    localparam logic [1:0] c_st_flush   = 2'd3;

    localparam int              c_cnt_w     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_flush_init = c_cnt_w'(FLUSH_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_xfer;
    logic               w_illegal_f3;
    logic [2:0]         w_map_op;
    logic               w_mispredict;
    logic               w_cmp_taken;

    logic [2:0]         r_cmp_op;
    logic [31:0]        r_pc;
    logic [31:0]        r_target;
    logic               r_pred_taken;
    logic               r_taken;
    logic               r_resolved_valid;
    logic               r_redirect_valid;
    logic [31:0]        r_redirect_pc;
    logic               r_illegal;
    logic [c_cnt_w-1:0] r_flush_cnt;

    assign br_ready     = (r_state == c_st_idle) && !rst;
    assign w_xfer       = br_valid && br_ready && !stall;
    assign w_cmp_taken  = |cmp_result;
    assign w_mispredict = (r_taken != r_pred_taken);

    // funct3 -> compare-unit opcode; BEQ/BNE swap, the signed/unsigned forms pass through
    always_comb begin
        w_map_op     = br_funct3;
        w_illegal_f3 = 1'b0;
        case (br_funct3)
            3'b000:         w_map_op = 3'b001;
            3'b001:         w_map_op = 3'b000;
            3'b010, 3'b011: w_illegal_f3 = 1'b1;
            default:        w_map_op = br_funct3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_xfer && !w_illegal_f3) begin
                    w_state_nxt = c_st_compare;
                end
            end
            c_st_compare: begin
                if (!stall) begin
                    w_state_nxt = c_st_resolve;
                end
            end
            c_st_resolve: begin
                if (!stall) begin
                    w_state_nxt = w_mispredict ? c_st_flush : c_st_idle;
                end
            end
            c_st_flush: begin
                if (!stall && (r_flush_cnt == '0)) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Pulse outputs clear only on a non-stalled edge so a stall holds them without re-issuing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp_op         <= 3'b000;
            r_pc             <= '0;
            r_target         <= '0;
            r_pred_taken     <= 1'b0;
            r_taken          <= 1'b0;
            r_resolved_valid <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_illegal        <= 1'b0;
            r_flush_cnt      <= '0;
        end else begin
            if (!stall) begin
                r_resolved_valid <= 1'b0;
                r_redirect_valid <= 1'b0;
                r_illegal        <= 1'b0;
            end

            if (w_xfer) begin
                if (w_illegal_f3) begin
                    r_illegal <= 1'b1;
                end else begin
                    r_cmp_op     <= w_map_op;
                    r_pc         <= br_pc;
                    r_target     <= br_target;
                    r_pred_taken <= br_pred_taken;
                end
            end

            if ((r_state == c_st_compare) && !stall) begin
                r_taken          <= w_cmp_taken;
                r_resolved_valid <= 1'b1;
                r_redirect_valid <= (w_cmp_taken != r_pred_taken);
                if (w_cmp_taken != r_pred_taken) begin
                    r_redirect_pc <= w_cmp_taken ? r_target : (r_pc + 32'd4);
                end
            end

            if ((r_state == c_st_resolve) && !stall && w_mispredict) begin
                r_flush_cnt <= c_flush_init;
            end else if ((r_state == c_st_flush) && !stall && (r_flush_cnt != '0)) begin
                r_flush_cnt <= r_flush_cnt - c_cnt_one;
            end
        end
    end

    assign cmp_op         = r_cmp_op;
    assign resolved_valid = r_resolved_valid;
    assign resolved_taken = r_taken;
    assign illegal_branch = r_illegal;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush_if       = (r_state == c_st_flush);
    assign flush_id       = (r_state == c_st_flush);

`ifdef BRANCH_RESOLVE_CTRL_BHT_EN
    localparam int IDX = (BHT_ENTRIES > 2) ? $clog2(BHT_ENTRIES) : 1;

    logic [1:0]     w_bht [BHT_ENTRIES];
    logic [IDX-1:0] w_upd_idx;
    logic           w_bht_upd;
    logic           w_unused_lookup;

    assign w_upd_idx = r_pc[IDX+1:2];
    assign w_bht_upd = (r_state == c_st_resolve) && !stall;

    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
        localparam logic [IDX-1:0] c_idx = IDX'(gi);
        logic [1:0] r_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= 2'b01;
            end else if (w_bht_upd && (w_upd_idx == c_idx)) begin
                if (r_taken && (r_cnt != 2'b11)) begin
                    r_cnt <= r_cnt + 2'b01;
                end else if (!r_taken && (r_cnt != 2'b00)) begin
                    r_cnt <= r_cnt - 2'b01;
                end
            end
        end

        assign w_bht[gi] = r_cnt;
    end

    // Counter update lands on the clock edge, so a same-cycle lookup sees the old value.
    assign lookup_taken    = w_bht[lookup_pc[IDX+1:2]][1];
    assign w_unused_lookup = ^{lookup_pc[31:IDX+2], lookup_pc[1:0]};
`else
    localparam int c_unused_bht_entries = BHT_ENTRIES;
    logic w_unused_lookup;

    assign lookup_taken    = 1'b0;
    assign w_unused_lookup = ^lookup_pc;
`endif

endmodule

`default_nettype wire
